fft32_serial_tx_ctrl: RTL and testbench
=======================================

# fft32_serial_tx_ctrl

Output-side sequencer for the serial 32-point FFT. After a frame is computed, it walks the 32-entry result buffer in output order and fetches each complex bin. It then streams every bin MSB-first as one contiguous serial bit stream: 16-bit real, then 16-bit imaginary. It owns the buffer read port, the 32-bit load/shift register and all framing strobes, so downstream logic sees a gap-free 1024-bit frame.

## Interface
- `N_POINTS`, 32, bins per frame; fixed at 32, so the address width is 5.
- `DW`, 16, width of each real/imag component.
- `BIT_REVERSE`, 1: 1 emits bin k from buffer address bitrev5(k); 0 emits from address k.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request, sampled each cycle; accepted only when `busy`=0.
- `abort`  in  1  synchronous cancel of the frame in progress.
- `busy`  out  1  high from the cycle after accept through the last bit of the frame.
- `rd_en`  out  1  buffer read strobe; read data arrives exactly 1 cycle later.
- `rd_addr`  out  5  buffer read address.
- `rd_re`  in  DW  signed real part, valid the cycle after `rd_en`.
- `rd_im`  in  DW  signed imaginary part, valid the cycle after `rd_en`.
- `ser_out`  out  1  serial data = shift_reg[31].
- `ser_valid`  out  1  `ser_out` carries a frame bit this cycle.
- `ser_word`  out  1  first bit (MSB) of every 16-bit word.
- `ser_frame`  out  1  first bit of the frame (bin 0 real MSB).
- `done`  out  1  one-cycle pulse after the last bit of a completed frame.

## Operation
- States: IDLE, FETCH, STREAM.
- Internal state: 32-bit shift_reg, 5-bit bin counter `bin`, 5-bit bit counter `bitc`.
- **IDLE**
  - `start`=1 and `abort`=0 → FETCH; `bin`←0.
- **FETCH** (1 cycle)
  - `rd_en`=1, `rd_addr`=map(0).
  - Unconditionally → STREAM.
  - At this edge: shift_reg←{rd_re, rd_im}, `bitc`←0, `ser_valid` register←1.
  - map(k) = bitrev5(k) when `BIT_REVERSE`=1, else k.
- **STREAM**, each cycle:
  - shift_reg←shift_reg<<1 and `bitc`←`bitc`+1 (wraps 31→0).
  - When `bitc`==30 and `bin`<31: `rd_en`=1, `rd_addr`=map(`bin`+1).
  - When `bitc`==31 and `bin`<31: shift_reg←{rd_re, rd_im} (overrides the shift), `bin`←`bin`+1.
  - When `bitc`==31 and `bin`==31: → IDLE, `done` pulses next cycle.
- `ser_word`=`ser_valid`&&(`bitc`==0 || `bitc`==16).
- `ser_frame`=`ser_valid`&&`bitc`==0&&`bin`==0.
- Data is the raw two's-complement words; no scaling or rounding.
- **Abort:** `abort`=1 in FETCH or STREAM → IDLE next edge.
  - `ser_valid`, `busy` and `rd_en` go low that edge.
  - No `done` pulse.
  - shift_reg is not cleared.
  - `abort` in IDLE is a no-op and takes priority over a simultaneous `start`.
- `start` while `busy`=1 is ignored; it is not queued.
- `start` in the same cycle as `done` is accepted, so frames run back-to-back with a 2-cycle gap in `ser_valid`.
- **Reset:** `rst_n` low at any time, including mid-frame, forces IDLE immediately.
  - shift_reg, `bin`, `bitc` are cleared.
  - All outputs are 0: `busy`, `rd_en`, `rd_addr`, `ser_out`, `ser_valid`, `ser_word`, `ser_frame`, `done`.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: FETCH; `busy`=1, `rd_en`=1, `rd_addr`=map(0).
- Cycle 2: first bit on `ser_out` = bin0 re[15]; `ser_valid`=`ser_word`=`ser_frame`=1.
- Cycles 2..1025: 1024 contiguous `ser_valid` cycles.
  - Bin k real MSB appears at cycle 2+32k.
  - Bin k imag MSB appears at cycle 18+32k.
- Read for bin k+1 is issued at cycle 32+32k, i.e. when `bitc`==30.
- Cycle 1026: `done`=1, `busy`=0, `ser_valid`=0.
- Latency from `start` to first bit: 2 cycles. Throughput: 1 bit/cycle, with no bubbles inside a frame.
- `rd_en` is a single-cycle pulse: exactly 32 pulses per completed frame.
- `rd_addr` holds its last value when `rd_en`=0.

## Test plan
- **Reset values:** hold `rst_n`=0 → all outputs 0. Release, wait 10 cycles with no `start` → outputs stay 0 and `rd_en` never pulses.
- **Single frame, `BIT_REVERSE`=1:**
  - Stimulus: buffer[a] = re 16'h8000|a, im 16'h0F00|a; `start` at cycle 0.
  - Required `rd_addr` sequence: 0,16,8,24,4,…,31.
  - Deserialised stream matches {re,im} per bin; `ser_frame` only at cycle 2; `ser_word` 64 times; `done` at cycle 1026.
- **`BIT_REVERSE`=0, negative data:**
  - Stimulus: re=-1 (16'hFFFF), im=-32768 (16'h8000) in all bins.
  - Each bin's bits are 16 ones, then 1 followed by 15 zeros.
  - Addresses run 0..31 in order.
- **Back-to-back frames:** `start` held high continuously.
  - Second frame accepted on the `done` cycle.
  - `ser_valid` is low for exactly 2 cycles between frames.
  - A `start` raised mid-frame has no effect.
- **Abort mid-frame:** `abort` at bin 5, `bitc` 10.
  - Next cycle: `busy`=`ser_valid`=0, no `done`.
  - A new `start` then produces a clean frame beginning at bin 0.
- **Async reset mid-frame:** drop `rst_n` at bin 20, between clock edges.
  - Outputs go 0 immediately, not on the next edge.
  - After release, a `start` yields a full 1024-bit frame.

Source files
------------

// File: rtl/fft32_serial_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fft32_serial_tx_ctrl_if
// Purpose  : Buffer read port, serial stream and frame control bundle for
//            the serial 32-point FFT output sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface fft32_serial_tx_ctrl_if #(
    parameter int DW = 16
);
    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 rd_en;
    logic [4:0]           rd_addr;
    logic signed [DW-1:0] rd_re;
    logic signed [DW-1:0] rd_im;
    logic                 ser_out;
    logic                 ser_valid;
    logic                 ser_word;
    logic                 ser_frame;
    logic                 done;

    // The sequencer side owns the read port and every framing strobe.
    modport master (
        input  start, abort, rd_re, rd_im,
        output busy, rd_en, rd_addr, ser_out, ser_valid, ser_word, ser_frame, done
    );

    modport slave (
        output start, abort, rd_re, rd_im,
        input  busy, rd_en, rd_addr, ser_out, ser_valid, ser_word, ser_frame, done
    );
endinterface
`default_nettype wire

// File: rtl/fft32_serial_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft32_serial_tx_ctrl
// Purpose  : Walks the 32-bin FFT result buffer in output order and streams
//            each bin MSB-first as {re, im} in one gap-free 1024-bit frame.
// Revision : 1.0 - initial release
// ============================================================================
module fft32_serial_tx_ctrl #(
    parameter int N_POINTS    = 32,
    parameter int DW          = 16,
    parameter int BIT_REVERSE = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    fft32_serial_tx_ctrl_if.master bus
);
    localparam int             c_AW       = $clog2(N_POINTS);
    localparam int             c_SW       = 2 * DW;
    localparam int             c_BW       = $clog2(c_SW);
    localparam logic [c_AW-1:0] c_BIN_LAST = c_AW'(N_POINTS - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(c_SW - 1);
    localparam logic [c_BW-1:0] c_BIT_PRE  = c_BW'(c_SW - 2);
    localparam logic [c_BW-1:0] c_BIT_HALF = c_BW'(DW);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t            r_state_q, w_state_d;
    logic [c_SW-1:0]   r_shift_q, w_shift_d;
    logic [c_AW-1:0]   r_bin_q, w_bin_d;
    logic [c_BW-1:0]   r_bitc_q, w_bitc_d;
    logic              r_ser_valid_q, w_ser_valid_d;
    logic              r_done_q, w_done_d;
    logic [c_AW-1:0]   r_rd_addr_q, w_rd_addr_d;
    logic              w_rd_en;
    logic [c_AW-1:0]   w_fetch_idx;
    logic [c_AW-1:0]   w_fetch_addr;

    // Bin index of the next read: 0 on the frame's first fetch, bin+1 ahead of each word boundary.
    assign w_fetch_idx = (r_state_q == S_STREAM) ? (r_bin_q + 1'b1) : '0;

    generate
        if (BIT_REVERSE != 0) begin : g_bitrev
            for (genvar gi = 0; gi < c_AW; gi++) begin : g_bit
                assign w_fetch_addr[gi] = w_fetch_idx[c_AW-1-gi];
            end
        end else begin : g_linear
            assign w_fetch_addr = w_fetch_idx;
        end
    endgenerate

    assign w_rd_addr_d = w_rd_en ? w_fetch_addr : r_rd_addr_q;

    always_comb begin
        w_state_d = r_state_q;
        w_shift_d = r_shift_q;
        w_bin_d   = r_bin_q;
        w_bitc_d  = r_bitc_q;
        w_done_d  = 1'b0;
        w_rd_en   = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_d = S_FETCH;
                    w_bin_d   = '0;
                end
            end
            S_FETCH: begin
                w_rd_en = 1'b1;
                if (bus.abort) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_state_d = S_STREAM;
                    w_shift_d = {bus.rd_re, bus.rd_im};
                    w_bitc_d  = '0;
                end
            end
            S_STREAM: begin
                // Prefetch one cycle early so the next word is ready exactly on the boundary.
                w_rd_en = (r_bitc_q == c_BIT_PRE) && (r_bin_q != c_BIN_LAST);
                if (bus.abort) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_shift_d = {r_shift_q[c_SW-2:0], 1'b0};
                    w_bitc_d  = r_bitc_q + 1'b1;
                    if (r_bitc_q == c_BIT_LAST) begin
                        if (r_bin_q != c_BIN_LAST) begin
                            w_shift_d = {bus.rd_re, bus.rd_im};
                            w_bin_d   = r_bin_q + 1'b1;
                        end else begin
                            w_state_d = S_IDLE;
                            w_done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
        w_ser_valid_d = (w_state_d == S_STREAM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= S_IDLE;
            r_shift_q     <= '0;
            r_bin_q       <= '0;
            r_bitc_q      <= '0;
            r_ser_valid_q <= 1'b0;
            r_done_q      <= 1'b0;
            r_rd_addr_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_shift_q     <= w_shift_d;
            r_bin_q       <= w_bin_d;
            r_bitc_q      <= w_bitc_d;
            r_ser_valid_q <= w_ser_valid_d;
            r_done_q      <= w_done_d;
            r_rd_addr_q   <= w_rd_addr_d;
        end
    end

    assign bus.busy      = (r_state_q != S_IDLE);
    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr   = w_rd_addr_d;
    assign bus.ser_out   = r_shift_q[c_SW-1];
    assign bus.ser_valid = r_ser_valid_q;
    assign bus.ser_word  = r_ser_valid_q && ((r_bitc_q == '0) || (r_bitc_q == c_BIT_HALF));
    assign bus.ser_frame = r_ser_valid_q && (r_bitc_q == '0) && (r_bin_q == '0);
    assign bus.done      = r_done_q;
endmodule
`default_nettype wire

// File: tb/tb_fft32_serial_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft32_serial_tx_ctrl
// Purpose  : Directed bench for fft32_serial_tx_ctrl with a queued
//            bit/address scoreboard; bit-reversed and linear instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft32_serial_tx_ctrl;
    localparam logic [15:0] c_POISON = 16'h5A5A;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int n_word = 0;
    int n_frame = 0;
    int n_rd   = 0;
    bit sel    = 1'b0;

    typedef struct packed {
        logic dat;
        logic wrd;
        logic frm;
    } exp_t;

    exp_t       sb_bits[$];
    logic [4:0] sb_addr[$];

    fft32_serial_tx_ctrl_if #(.DW(16)) ri ();
    fft32_serial_tx_ctrl_if #(.DW(16)) li ();

    fft32_serial_tx_ctrl #(.N_POINTS(32), .DW(16), .BIT_REVERSE(1)) u_rev (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ri.master)
    );

    fft32_serial_tx_ctrl #(.N_POINTS(32), .DW(16), .BIT_REVERSE(0)) u_lin (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (li.master)
    );

    function automatic logic [15:0] buf_re(input bit s, input logic [4:0] a);
        return s ? 16'hFFFF : (16'h8000 | {11'd0, a});
    endfunction

    function automatic logic [15:0] buf_im(input bit s, input logic [4:0] a);
        return s ? 16'h8000 : (16'h0F00 | {11'd0, a});
    endfunction

    function automatic logic [4:0] bitrev5(input logic [4:0] k);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = k[4-i];
        return r;
    endfunction

    // Buffer models: data is only meaningful in the strobe cycle and the cycle after.
    logic rev_prev, lin_prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rev_prev <= 1'b0;
            lin_prev <= 1'b0;
        end else begin
            rev_prev <= ri.rd_en;
            lin_prev <= li.rd_en;
        end
    end
    assign ri.rd_re = (ri.rd_en || rev_prev) ? buf_re(1'b0, ri.rd_addr) : c_POISON;
    assign ri.rd_im = (ri.rd_en || rev_prev) ? buf_im(1'b0, ri.rd_addr) : c_POISON;
    assign li.rd_re = (li.rd_en || lin_prev) ? buf_re(1'b1, li.rd_addr) : c_POISON;
    assign li.rd_im = (li.rd_en || lin_prev) ? buf_im(1'b1, li.rd_addr) : c_POISON;

    // {busy, rd_en, rd_addr[4:0], ser_out, ser_valid, ser_word, ser_frame, done}
    function automatic logic [11:0] outs(input bit s);
        if (s)
            return {li.busy, li.rd_en, li.rd_addr, li.ser_out, li.ser_valid,
                    li.ser_word, li.ser_frame, li.done};
        return {ri.busy, ri.rd_en, ri.rd_addr, ri.ser_out, ri.ser_valid,
                ri.ser_word, ri.ser_frame, ri.done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_zero(input bit s, input string tag);
        chk(tag, 32'(outs(s)), 32'd0);
    endtask

    task automatic set_start(input bit s, input logic v);
        if (s) li.start = v;
        else   ri.start = v;
    endtask

    task automatic push_frame(input bit s);
        logic [4:0]  a;
        logic [31:0] w;
        exp_t        e;
        for (int k = 0; k < 32; k++) begin
            a = s ? 5'(k) : bitrev5(5'(k));
            sb_addr.push_back(a);
            w = {buf_re(s, a), buf_im(s, a)};
            for (int b = 0; b < 32; b++) begin
                e.dat = w[31-b];
                e.wrd = (b == 0) || (b == 16);
                e.frm = (k == 0) && (b == 0);
                sb_bits.push_back(e);
            end
        end
    endtask

    task automatic mon();
        logic [11:0] o;
        logic [11:0] q;
        exp_t        e;
        o = outs(sel);
        q = outs(!sel);
        chk("idle_instance_quiet", {30'd0, q[10], q[3]}, 32'd0);
        if (o[10]) begin
            n_rd++;
            if (sb_addr.size() == 0) chk("rd_en_unexpected", 32'(sb_addr.size()), 32'd1);
            else chk("rd_addr", {27'd0, o[9:5]}, {27'd0, sb_addr.pop_front()});
        end
        if (o[3]) begin
            if (o[2]) n_word++;
            if (o[1]) n_frame++;
            if (sb_bits.size() == 0) begin
                chk("ser_valid_unexpected", 32'(sb_bits.size()), 32'd1);
            end else begin
                e = sb_bits.pop_front();
                chk("ser_out",   32'(o[4]), 32'(e.dat));
                chk("ser_word",  32'(o[2]), 32'(e.wrd));
                chk("ser_frame", 32'(o[1]), 32'(e.frm));
            end
        end else begin
            chk("strobes_without_valid", {30'd0, o[2], o[1]}, 32'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit s, inout int n);
        logic [11:0] o;
        o = outs(s);
        while (!o[0] && n < 1100) begin
            tick();
            n++;
            o = outs(s);
        end
    endtask

    task automatic run_frame(input bit s);
        int          n, w0, f0, r0;
        logic [11:0] o;
        push_frame(s);
        w0 = n_word; f0 = n_frame; r0 = n_rd;
        set_start(s, 1'b1);
        tick();
        set_start(s, 1'b0);
        o = outs(s);
        chk("fetch_busy_rd_en", {30'd0, o[11], o[10]}, 32'd3);
        n = 1;
        wait_done(s, n);
        chk("done_cycle", 32'(n), 32'd1026);
        chk("word_count", 32'(n_word - w0), 32'd64);
        chk("frame_count", 32'(n_frame - f0), 32'd1);
        chk("rd_pulses", 32'(n_rd - r0), 32'd32);
        chk("scoreboard_empty", 32'(sb_bits.size() + sb_addr.size()), 32'd0);
        o = outs(s);
        chk("done_busy_valid", {30'd0, o[11], o[3]}, 32'd0);
        tick();
        o = outs(s);
        chk("done_one_cycle", {31'd0, o[0]}, 32'd0);
    endtask

    initial begin
        logic [11:0] o;
        int          n, w0;
        ri.start = 1'b0; ri.abort = 1'b0;
        li.start = 1'b0; li.abort = 1'b0;

        // Reset values and quiet idle
        #1 rst_n = 1'b0;
        #1;
        chk_zero(0, "reset_rev");
        chk_zero(1, "reset_lin");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_zero(0, "idle_rev");
            chk_zero(1, "idle_lin");
        end

        // abort beats start in IDLE
        ri.start = 1'b1; ri.abort = 1'b1;
        tick();
        ri.start = 1'b0; ri.abort = 1'b0;
        o = outs(0);
        chk("abort_priority_idle", {31'd0, o[11]}, 32'd0);
        tick();

        // Single frame, bit-reversed order
        run_frame(0);
        tick();

        // Linear order, negative data
        sel = 1'b1;
        tick();
        run_frame(1);
        sel = 1'b0;
        tick();

        // Back-to-back with start held high
        push_frame(0);
        push_frame(0);
        w0 = n_word;
        ri.start = 1'b1;
        tick();
        n = 1;
        wait_done(0, n);
        chk("b2b_first_done", 32'(n), 32'd1026);
        o = outs(0);
        chk("b2b_gap_done_cycle", {31'd0, o[3]}, 32'd0);
        tick();
        o = outs(0);
        chk("b2b_accept_on_done", {30'd0, o[11], o[3]}, 32'd2);
        tick();
        o = outs(0);
        chk("b2b_resume", {30'd0, o[3], o[1]}, 32'd3);
        n = 2;
        o = outs(0);
        while (!o[0] && n < 1100) begin
            if (n == 500) ri.start = 1'b0;
            tick();
            n++;
            o = outs(0);
        end
        chk("b2b_second_done", 32'(n), 32'd1026);
        chk("b2b_words", 32'(n_word - w0), 32'd128);
        tick();
        o = outs(0);
        chk("b2b_no_third", {31'd0, o[11]}, 32'd0);
        chk("b2b_scoreboard_empty", 32'(sb_bits.size() + sb_addr.size()), 32'd0);
        tick();

        // Abort at bin 5, bit 10 (cycle 172)
        push_frame(0);
        ri.start = 1'b1;
        tick();
        ri.start = 1'b0;
        repeat (171) tick();
        ri.abort = 1'b1;
        tick();
        ri.abort = 1'b0;
        sb_bits.delete();
        sb_addr.delete();
        o = outs(0);
        chk("abort_idle", {29'd0, o[11], o[3], o[0]}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            o = outs(0);
            chk("abort_no_done", {30'd0, o[11], o[0]}, 32'd0);
        end
        run_frame(0);
        tick();

        // Asynchronous reset at bin 20 (cycle 650), between edges
        push_frame(0);
        ri.start = 1'b1;
        tick();
        ri.start = 1'b0;
        repeat (649) tick();
        #2 rst_n = 1'b0;
        #1;
        sb_bits.delete();
        sb_addr.delete();
        chk_zero(0, "async_reset_immediate");
        tick();
        chk_zero(0, "reset_held");
        rst_n = 1'b1;
        tick();
        tick();
        run_frame(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
